// File: rtl/cpu_reg_snapshot.sv
// rtl/cpu_reg_snapshot.sv - shadow register bank with four-phase snapshot freeze
module cpu_reg_snapshot #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CCLK,
    input  logic        CRST,
    input  logic        WB_EN,
    input  logic [4:0]  WB_ADDR,
    input  logic [31:0] WB_DATA,
    input  logic        RET_VALID,
    input  logic [31:0] RET_PC,
    input  logic        SNAP_REQ,
    output logic        SNAP_ACK,
    output logic        FROZEN,
    output logic [31:0] REG00, REG01, REG02, REG03, REG04, REG05, REG06, REG07,
    output logic [31:0] REG08, REG09, REG10, REG11, REG12, REG13, REG14, REG15,
    output logic [31:0] REG16, REG17, REG18, REG19, REG20, REG21, REG22, REG23,
    output logic [31:0] REG24, REG25, REG26, REG27, REG28, REG29, REG30, REG31,
    output logic [31:0] REGPC,
    output logic [31:0] RETIRED
);
    typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

    state_t      state;
    logic [31:0] live [1:31];
    logic [31:0] live_pc, live_cnt;
    logic [31:0] out_r [1:31];
    logic [31:0] out_pc, out_cnt;
    logic [31:0] live_nxt [1:31];
    logic [31:0] live_pc_nxt, live_cnt_nxt;

    // Next-state live bank; the output bank copies this so same-edge updates are included.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            live_nxt[i] = live[i];
            if (WB_EN && WB_ADDR == 5'(i))
                live_nxt[i] = WB_DATA;
        end
        live_pc_nxt  = RET_VALID ? RET_PC : live_pc;
        live_cnt_nxt = (RET_VALID && live_cnt != 32'hFFFF_FFFF) ? live_cnt + 32'd1 : live_cnt;
    end

    always_ff @(posedge CCLK) begin
        if (CRST) begin
            state    <= IDLE;
            SNAP_ACK <= 1'b0;
            FROZEN   <= 1'b0;
            for (int i = 1; i < 32; i++) begin
                live[i]  <= '0;
                out_r[i] <= '0;
            end
            live_pc  <= RESET_PC;
            live_cnt <= '0;
            out_pc   <= RESET_PC;
            out_cnt  <= '0;
        end else begin
            for (int i = 1; i < 32; i++)
                live[i] <= live_nxt[i];
            live_pc  <= live_pc_nxt;
            live_cnt <= live_cnt_nxt;
            if (state != HOLD) begin
                for (int i = 1; i < 32; i++)
                    out_r[i] <= live_nxt[i];
                out_pc  <= live_pc_nxt;
                out_cnt <= live_cnt_nxt;
            end
            case (state)
                IDLE: if (SNAP_REQ) begin
                    state    <= HOLD;
                    SNAP_ACK <= 1'b1;
                    FROZEN   <= 1'b1;
                end
                HOLD: if (!SNAP_REQ) begin
                    state    <= RELEASE;
                    SNAP_ACK <= 1'b0;
                    FROZEN   <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    SNAP_ACK <= 1'b0;
                    FROZEN   <= 1'b0;
                end
            endcase
        end
    end

    assign REG00 = '0;
    assign REG01 = out_r[1];
    assign REG02 = out_r[2];
    assign REG03 = out_r[3];
    assign REG04 = out_r[4];
    assign REG05 = out_r[5];
    assign REG06 = out_r[6];
    assign REG07 = out_r[7];
    assign REG08 = out_r[8];
    assign REG09 = out_r[9];
    assign REG10 = out_r[10];
    assign REG11 = out_r[11];
    assign REG12 = out_r[12];
    assign REG13 = out_r[13];
    assign REG14 = out_r[14];
    assign REG15 = out_r[15];
    assign REG16 = out_r[16];
    assign REG17 = out_r[17];
    assign REG18 = out_r[18];
    assign REG19 = out_r[19];
    assign REG20 = out_r[20];
    assign REG21 = out_r[21];
    assign REG22 = out_r[22];
    assign REG23 = out_r[23];
    assign REG24 = out_r[24];
    assign REG25 = out_r[25];
    assign REG26 = out_r[26];
    assign REG27 = out_r[27];
    assign REG28 = out_r[28];
    assign REG29 = out_r[29];
    assign REG30 = out_r[30];
    assign REG31 = out_r[31];
    assign REGPC   = out_pc;
    assign RETIRED = out_cnt;
endmodule

// File: tb/tb_cpu_reg_snapshot.sv
// tb/tb_cpu_reg_snapshot.sv - self-checking bench for cpu_reg_snapshot
module tb_cpu_reg_snapshot;
    logic        CCLK = 1'b0;
    logic        CRST, WB_EN, RET_VALID, SNAP_REQ;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA, RET_PC;
    logic        ack, frz, ack_b, frz_b;
    logic [31:0] regs [32];
    logic [31:0] regs_b [32];
    logic [31:0] pc, cnt, pc_b, cnt_b;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural state, snapshot copy, and handshake phase
    logic [31:0] m_live [32];
    logic [31:0] m_pc, m_cnt;
    logic [31:0] m_out [32];
    logic [31:0] m_opc, m_ocnt;
    int          m_phase;   // 0 idle, 1 holding, 2 releasing
    logic [31:0] snap_cnt;

    always #5 CCLK = ~CCLK;

    cpu_reg_snapshot dut (
        .CCLK(CCLK), .CRST(CRST), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .RET_VALID(RET_VALID), .RET_PC(RET_PC), .SNAP_REQ(SNAP_REQ),
        .SNAP_ACK(ack), .FROZEN(frz),
        .REG00(regs[0]),  .REG01(regs[1]),  .REG02(regs[2]),  .REG03(regs[3]),
        .REG04(regs[4]),  .REG05(regs[5]),  .REG06(regs[6]),  .REG07(regs[7]),
        .REG08(regs[8]),  .REG09(regs[9]),  .REG10(regs[10]), .REG11(regs[11]),
        .REG12(regs[12]), .REG13(regs[13]), .REG14(regs[14]), .REG15(regs[15]),
        .REG16(regs[16]), .REG17(regs[17]), .REG18(regs[18]), .REG19(regs[19]),
        .REG20(regs[20]), .REG21(regs[21]), .REG22(regs[22]), .REG23(regs[23]),
        .REG24(regs[24]), .REG25(regs[25]), .REG26(regs[26]), .REG27(regs[27]),
        .REG28(regs[28]), .REG29(regs[29]), .REG30(regs[30]), .REG31(regs[31]),
        .REGPC(pc), .RETIRED(cnt)
    );

    cpu_reg_snapshot #(.RESET_PC(32'h0000_1000)) dut_b (
        .CCLK(CCLK), .CRST(CRST), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .RET_VALID(RET_VALID), .RET_PC(RET_PC), .SNAP_REQ(SNAP_REQ),
        .SNAP_ACK(ack_b), .FROZEN(frz_b),
        .REG00(regs_b[0]),  .REG01(regs_b[1]),  .REG02(regs_b[2]),  .REG03(regs_b[3]),
        .REG04(regs_b[4]),  .REG05(regs_b[5]),  .REG06(regs_b[6]),  .REG07(regs_b[7]),
        .REG08(regs_b[8]),  .REG09(regs_b[9]),  .REG10(regs_b[10]), .REG11(regs_b[11]),
        .REG12(regs_b[12]), .REG13(regs_b[13]), .REG14(regs_b[14]), .REG15(regs_b[15]),
        .REG16(regs_b[16]), .REG17(regs_b[17]), .REG18(regs_b[18]), .REG19(regs_b[19]),
        .REG20(regs_b[20]), .REG21(regs_b[21]), .REG22(regs_b[22]), .REG23(regs_b[23]),
        .REG24(regs_b[24]), .REG25(regs_b[25]), .REG26(regs_b[26]), .REG27(regs_b[27]),
        .REG28(regs_b[28]), .REG29(regs_b[29]), .REG30(regs_b[30]), .REG31(regs_b[31]),
        .REGPC(pc_b), .RETIRED(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s reg%0d", tag, i), regs[i], m_out[i]);
        chk({tag, " regpc"}, pc, m_opc);
        chk({tag, " retired"}, cnt, m_ocnt);
        chk({tag, " ack"}, {31'd0, ack}, {31'd0, m_phase == 1});
        chk({tag, " frozen"}, {31'd0, frz}, {31'd0, m_phase == 1});
    endtask

    task automatic model_edge(input logic rst, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic rv, input logic [31:0] rpc,
                              input logic req);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_live[i] = '0; m_out[i] = '0; end
            m_pc = 32'h0; m_cnt = 0; m_opc = 32'h0; m_ocnt = 0; m_phase = 0;
            return;
        end
        if (we && wa != 0) m_live[wa] = wd;
        if (rv) begin
            m_pc = rpc;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        if (m_phase != 1) begin
            m_out = m_live; m_opc = m_pc; m_ocnt = m_cnt;
        end
        if (m_phase == 0 && req)       m_phase = 1;
        else if (m_phase == 1 && !req) m_phase = 2;
        else if (m_phase == 2)         m_phase = 0;
    endtask

    task automatic step(input string tag, input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic rv, input logic [31:0] rpc,
                        input logic req);
        CRST = rst; WB_EN = we; WB_ADDR = wa; WB_DATA = wd;
        RET_VALID = rv; RET_PC = rpc; SNAP_REQ = req;
        @(posedge CCLK);
        model_edge(rst, we, wa, wd, rv, rpc, req);
        @(negedge CCLK);
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_live[i] = '0; m_out[i] = '0; end
        m_pc = 0; m_cnt = 0; m_opc = 0; m_ocnt = 0; m_phase = 0;

        step("rst0", 1, 1, 5'd3, 32'h55, 1, 32'h80, 1);
        step("rst1", 1, 0, 0, 0, 0, 0, 0);
        chk("rst pc_b", pc_b, 32'h0000_1000);
        chk("rst cnt_b", cnt_b, 32'h0);
        step("idle", 0, 0, 0, 0, 0, 0, 0);
        chk("idle regpc", pc, 32'h0);
        chk("idle pc_b", pc_b, 32'h0000_1000);

        step("wb5", 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
        chk("wb5 direct", regs[5], 32'hDEAD_BEEF);
        step("wb0", 0, 1, 5'd0, 32'h1234, 0, 0, 0);
        chk("wb0 direct", regs[0], 32'h0);

        step("coh pre", 0, 1, 5'd3, 32'd7, 1, 32'h40, 0);
        step("coh req", 0, 1, 5'd3, 32'd9, 0, 0, 1);
        chk("coh ack", {31'd0, ack}, 32'd1);
        chk("coh r3", regs[3], 32'd9);
        chk("coh pc", pc, 32'h40);
        snap_cnt = cnt;
        step("hold wr", 0, 1, 5'd3, 32'd11, 1, 32'h44, 1);
        step("hold r1", 0, 0, 0, 0, 1, 32'h48, 1);
        step("hold r2", 0, 0, 0, 0, 1, 32'h4C, 1);
        step("hold r3", 0, 0, 0, 0, 1, 32'h50, 1);
        chk("hold r3 frozen", regs[3], 32'd9);
        step("drop", 0, 0, 0, 0, 0, 0, 0);
        chk("drop ack", {31'd0, ack}, 32'd0);
        chk("drop r3 held", regs[3], 32'd9);
        step("release", 0, 0, 0, 0, 0, 0, 0);
        chk("rel r3", regs[3], 32'd11);
        chk("rel retired", cnt, snap_cnt + 32'd4);
        chk("rel pc", pc, 32'h50);

        step("rq hold", 0, 0, 0, 0, 0, 0, 1);
        step("rq drop m", 0, 0, 0, 0, 0, 0, 0);
        step("rq m+1", 0, 0, 0, 0, 0, 0, 1);
        chk("rq m+1 ack", {31'd0, ack}, 32'd0);
        step("rq m+2", 0, 0, 0, 0, 0, 0, 1);
        chk("rq m+2 ack", {31'd0, ack}, 32'd1);
        step("rq end0", 0, 0, 0, 0, 0, 0, 0);
        step("rq end1", 0, 0, 0, 0, 0, 0, 0);

        force dut.live_cnt = 32'hFFFF_FFFD;
        m_cnt = 32'hFFFF_FFFD;
        step("sat load", 0, 0, 0, 0, 0, 0, 0);
        release dut.live_cnt;
        step("sat1", 0, 0, 0, 0, 1, 32'h100, 0);
        chk("sat1 direct", cnt, 32'hFFFF_FFFE);
        step("sat2", 0, 0, 0, 0, 1, 32'h104, 0);
        chk("sat2 direct", cnt, 32'hFFFF_FFFF);
        step("sat3", 0, 0, 0, 0, 1, 32'h108, 0);
        chk("sat3 direct", cnt, 32'hFFFF_FFFF);

        step("hr w7", 0, 1, 5'd7, 32'd5, 0, 0, 0);
        step("hr req", 0, 0, 0, 0, 0, 0, 1);
        step("hr rst", 1, 1, 5'd7, 32'd6, 1, 32'h200, 1);
        chk("hr ack", {31'd0, ack}, 32'd0);
        chk("hr frozen", {31'd0, frz}, 32'd0);
        chk("hr r7", regs[7], 32'd0);
        chk("hr pc", pc, 32'h0);

        begin
            logic req_lvl = 0;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 5) == 0) req_lvl = ~req_lvl;
                step("rand", $urandom_range(0, 60) == 0, 1'($urandom), 5'($urandom),
                     $urandom, 1'($urandom), $urandom, req_lvl);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
